// File: rtl/mem_sched_rr_if.sv
// Bundle of cache-side and pmem-side signals around the round-robin pmem scheduler.
// Purely wiring, no latency of its own.
// No backpressure: requests are levels held until the matching resp pulse.
// Ports (slave = scheduler side):
//   I-cache : i_read, i_addr in; i_resp, i_rdata out
//   D-cache : d_read, d_write, d_addr, d_wdata in; d_resp, d_rdata out
//   pmem    : pmem_resp, pmem_rdata in; pmem_read, pmem_write, pmem_address, pmem_wdata out
//   status  : err_timeout out (sticky)
interface mem_sched_rr_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;

  logic              err_timeout;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_resp, pmem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata,
           pmem_read, pmem_write, pmem_address, pmem_wdata, err_timeout
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_resp, pmem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata,
           pmem_read, pmem_write, pmem_address, pmem_wdata, err_timeout
  );
endinterface

// File: rtl/mem_sched_rr.sv
// Round-robin scheduler of I-cache / D-cache line requests onto one registered pmem port.
// Latency: grant at the sampling edge, pmem command from the next cycle; cache resp same cycle as pmem_resp.
// Backpressure: requesters hold their level request until resp; one RECOVER cycle after each transaction.
// Ports: clk, rst_n (async active-low) plus the mem_sched_rr_if slave modport (cache and pmem sides,
// sticky err_timeout raised after TIMEOUT busy cycles without pmem_resp).
module mem_sched_rr #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  mem_sched_rr_if.slave bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_grant_d;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [ADDR_W-1:0] r_pmem_address;
  logic [LINE_W-1:0] r_pmem_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;
  logic w_busy;

  assign w_i_req = bus.i_read;
  assign w_d_req = bus.d_read | bus.d_write;
  assign w_busy  = (r_state == BUSY_I) || (r_state == BUSY_D);

  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie, the requester that did not win last time goes first.
        if (w_i_req && w_d_req) begin
          w_grant_i = r_last_grant_d;
          w_grant_d = ~r_last_grant_d;
        end else begin
          w_grant_i = w_i_req;
          w_grant_d = w_d_req;
        end
        if (w_grant_i)      w_next_state = BUSY_I;
        else if (w_grant_d) w_next_state = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        if (bus.pmem_resp) w_next_state = RECOVER;
      end
      RECOVER: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_last_grant_d <= 1'b1;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_cnt          <= '0;
      r_err          <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_i) begin
        r_pmem_read    <= 1'b1;
        r_pmem_write   <= 1'b0;
        r_pmem_address <= bus.i_addr;
        r_last_grant_d <= 1'b0;
        r_cnt          <= '0;
      end else if (w_grant_d) begin
        // Writeback has priority over a simultaneous read request.
        r_pmem_read    <= ~bus.d_write;
        r_pmem_write   <= bus.d_write;
        r_pmem_address <= bus.d_addr;
        r_pmem_wdata   <= bus.d_wdata;
        r_last_grant_d <= 1'b1;
        r_cnt          <= '0;
      end else if (w_busy) begin
        if (bus.pmem_resp) begin
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
        end else if (r_cnt != CNT_MAX) begin
          // Counter saturates at TIMEOUT; the flag is set on the same edge it gets there.
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_MAX - 1'b1) r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_write   = r_pmem_write;
  assign bus.pmem_address = r_pmem_address;
  assign bus.pmem_wdata   = r_pmem_wdata;
  assign bus.i_resp       = bus.pmem_resp & (r_state == BUSY_I);
  assign bus.d_resp       = bus.pmem_resp & (r_state == BUSY_D);
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;
  assign bus.err_timeout  = r_err;

endmodule

// File: tb/tb_mem_sched_rr.sv
// Directed bench for mem_sched_rr: vector table for round-robin alternation plus hand sequences.
// Inputs are driven on the falling edge and outputs checked 1 time unit later.
// The DUT is built with TIMEOUT=4 so the timeout path is reachable quickly.
module tb_mem_sched_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_sched_rr_if #(.ADDR_W(32), .LINE_W(256)) bus ();

  mem_sched_rr #(.ADDR_W(32), .LINE_W(256), .TIMEOUT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        ir, dr, dw, rsp;
    logic        e_rd, e_wr, e_ir, e_dr;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic ir, dr, dw, rsp, e_rd, e_wr, e_ir, e_dr,
                              input logic [31:0] e_addr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.rsp = rsp;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_ir = e_ir; v.e_dr = e_dr;
    v.e_addr = e_addr;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chka(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fall();
    @(negedge clk);
  endtask

  task automatic do_reset();
    fall();
    rst_n = 1'b0;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.pmem_resp = 1'b0;
    fall();
    rst_n = 1'b1;
  endtask

  logic [255:0] pat_a5;
  logic [255:0] pat_rd;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_rd = {8{32'hDEAD_BEEF}};
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;

    // Reset state
    fall(); #1;
    chk1("rst_pmem_read", bus.pmem_read, 1'b0);
    chk1("rst_pmem_write", bus.pmem_write, 1'b0);
    chka("rst_pmem_address", bus.pmem_address, 32'h0);
    chkw("rst_pmem_wdata", bus.pmem_wdata, 256'h0);
    chk1("rst_i_resp", bus.i_resp, 1'b0);
    chk1("rst_d_resp", bus.d_resp, 1'b0);
    chk1("rst_err", bus.err_timeout, 1'b0);
    rst_n = 1'b1;

    // Single I read, pmem_resp after 5 cycles
    fall();
    bus.i_addr = 32'h0000_0040; bus.i_read = 1'b1; #1;
    chk1("ird_before_grant", bus.pmem_read, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      fall(); #1;
      chk1("ird_pmem_read", bus.pmem_read, 1'b1);
      chka("ird_pmem_address", bus.pmem_address, 32'h40);
      chk1("ird_i_resp_wait", bus.i_resp, 1'b0);
    end
    fall();
    bus.pmem_resp = 1'b1; bus.pmem_rdata = pat_rd; #1;
    chk1("ird_i_resp", bus.i_resp, 1'b1);
    chkw("ird_i_rdata", bus.i_rdata, pat_rd);
    chk1("ird_d_resp", bus.d_resp, 1'b0);
    fall();
    bus.pmem_resp = 1'b0; bus.i_read = 1'b0; #1;
    chk1("ird_recover_read", bus.pmem_read, 1'b0);
    chk1("ird_resp_pulse", bus.i_resp, 1'b0);
    fall(); #1;

    // D writeback
    fall();
    bus.d_addr = 32'h8000_0020; bus.d_wdata = pat_a5; bus.d_write = 1'b1; #1;
    fall(); #1;
    chk1("dwb_pmem_write", bus.pmem_write, 1'b1);
    chk1("dwb_pmem_read", bus.pmem_read, 1'b0);
    chka("dwb_pmem_address", bus.pmem_address, 32'h8000_0020);
    chkw("dwb_pmem_wdata", bus.pmem_wdata, pat_a5);
    fall();
    bus.pmem_resp = 1'b1; #1;
    chk1("dwb_d_resp", bus.d_resp, 1'b1);
    chk1("dwb_i_resp", bus.i_resp, 1'b0);
    fall();
    bus.pmem_resp = 1'b0; bus.d_write = 1'b0; #1;
    chk1("dwb_recover_write", bus.pmem_write, 1'b0);

    // Timeout with TIMEOUT=4
    do_reset();
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_0080; #1;
    for (int c = 1; c <= 4; c++) begin
      fall(); #1;
      chk1("to_err_low", bus.err_timeout, 1'b0);
    end
    fall(); #1;
    chk1("to_err_set", bus.err_timeout, 1'b1);
    chk1("to_still_busy", bus.pmem_read, 1'b1);
    fall();
    bus.pmem_resp = 1'b1; #1;
    chk1("to_late_i_resp", bus.i_resp, 1'b1);
    fall();
    bus.pmem_resp = 1'b0; bus.i_read = 1'b0; #1;
    chk1("to_err_sticky1", bus.err_timeout, 1'b1);
    fall(); fall(); #1;
    chk1("to_err_sticky2", bus.err_timeout, 1'b1);
    do_reset(); #1;
    chk1("to_err_cleared", bus.err_timeout, 1'b0);

    // Round-robin alternation, write priority, drop mid-busy (fresh reset above: I wins first tie)
    bus.i_addr = 32'h0000_0100; bus.d_addr = 32'h0000_0200;
    //               ir dr dw rsp  rd wr ir dr  addr
    tbl[0]  = mk(1, 1, 0, 0,   0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 1, 0, 1,   1, 0, 1, 0, 32'h100);
    tbl[2]  = mk(1, 1, 0, 1,   0, 0, 0, 0, 32'h100);
    tbl[3]  = mk(1, 1, 0, 0,   0, 0, 0, 0, 32'h100);
    tbl[4]  = mk(1, 1, 0, 1,   1, 0, 0, 1, 32'h200);
    tbl[5]  = mk(1, 1, 0, 1,   0, 0, 0, 0, 32'h200);
    tbl[6]  = mk(1, 1, 0, 0,   0, 0, 0, 0, 32'h200);
    tbl[7]  = mk(1, 1, 0, 1,   1, 0, 1, 0, 32'h100);
    tbl[8]  = mk(0, 1, 1, 0,   0, 0, 0, 0, 32'h100);
    tbl[9]  = mk(0, 1, 1, 0,   0, 0, 0, 0, 32'h100);
    tbl[10] = mk(0, 0, 0, 0,   0, 1, 0, 0, 32'h200);
    tbl[11] = mk(0, 0, 0, 1,   0, 1, 0, 1, 32'h200);
    tbl[12] = mk(0, 0, 0, 0,   0, 0, 0, 0, 32'h200);
    for (int k = 0; k < 13; k++) begin
      fall();
      bus.i_read = tbl[k].ir; bus.d_read = tbl[k].dr;
      bus.d_write = tbl[k].dw; bus.pmem_resp = tbl[k].rsp;
      #1;
      chk1($sformatf("rr%0d_pmem_read", k), bus.pmem_read, tbl[k].e_rd);
      chk1($sformatf("rr%0d_pmem_write", k), bus.pmem_write, tbl[k].e_wr);
      chk1($sformatf("rr%0d_i_resp", k), bus.i_resp, tbl[k].e_ir);
      chk1($sformatf("rr%0d_d_resp", k), bus.d_resp, tbl[k].e_dr);
      chka($sformatf("rr%0d_pmem_address", k), bus.pmem_address, tbl[k].e_addr);
    end

    // Reset mid-BUSY_D
    fall();
    bus.d_addr = 32'h0000_0300; bus.d_wdata = pat_a5; bus.d_write = 1'b1; #1;
    fall(); #1;
    chk1("rb_busy_write", bus.pmem_write, 1'b1);
    fall();
    rst_n = 1'b0; bus.pmem_resp = 1'b1; #1;
    chk1("rb_pmem_read", bus.pmem_read, 1'b0);
    chk1("rb_pmem_write", bus.pmem_write, 1'b0);
    chka("rb_pmem_address", bus.pmem_address, 32'h0);
    chkw("rb_pmem_wdata", bus.pmem_wdata, 256'h0);
    chk1("rb_d_resp", bus.d_resp, 1'b0);
    chk1("rb_i_resp", bus.i_resp, 1'b0);
    fall();
    rst_n = 1'b1; bus.pmem_resp = 1'b0; bus.d_write = 1'b0;
    fall();
    bus.pmem_resp = 1'b1; #1;
    chk1("rb_stray_d_resp", bus.d_resp, 1'b0);
    chk1("rb_stray_i_resp", bus.i_resp, 1'b0);
    fall();
    bus.pmem_resp = 1'b0; bus.i_addr = 32'h0000_0500;
    bus.i_read = 1'b1; bus.d_read = 1'b1; #1;
    chk1("rb_stray_no_cmd", bus.pmem_read, 1'b0);
    fall(); #1;
    chk1("rb_tie_read", bus.pmem_read, 1'b1);
    chka("rb_tie_grant_i", bus.pmem_address, 32'h0000_0500);
    bus.i_read = 1'b0; bus.d_read = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_sched_rr.md
# mem_sched_rr

Round-robin scheduler between the instruction cache, the data cache and the single physical-memory port. It latches the winning request into registers and drives pmem from those registers, so pmem signals are glitch-free and stable for the whole transaction. It enforces fairness when both caches miss together, and watches each pmem transaction with a timeout counter. It sits between the split L1 caches and pmem/L2, one level below the caches.

## Interface
- ADDR_W, 32, address width
- LINE_W, 256, cache-line width
- TIMEOUT, 1023, busy cycles without pmem_resp before err_timeout is raised (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache line read request, level, held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_resp  out  1  I-cache transaction done, one-cycle pulse
- i_rdata  out  LINE_W  line data, valid when i_resp=1
- d_read, d_write  in  1  D-cache read / writeback request, level, held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  writeback line
- d_resp  out  1  D-cache transaction done, one-cycle pulse
- d_rdata  out  LINE_W  line data, valid when d_resp=1
- pmem_read, pmem_write  out  1  registered pmem command
- pmem_address  out  ADDR_W  registered address
- pmem_wdata  out  LINE_W  registered write line
- pmem_resp  in  1  pmem completion, one-cycle pulse
- pmem_rdata  in  LINE_W  valid with pmem_resp
- err_timeout  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY_I, BUSY_D, RECOVER.
- IDLE, at each edge:
  - i_req=i_read; d_req=d_read|d_write.
  - Only one request pending: grant it.
  - Both pending: grant the requester not granted last (last_grant register).
  - On grant: latch addr, op and d_wdata into pmem_* registers; update last_grant; enter BUSY_I or BUSY_D.
  - If d_read and d_write are both high, write wins.
- BUSY_x:
  - pmem_read/pmem_write held from the latched op; address and data frozen.
  - i_resp = pmem_resp & BUSY_I; d_resp = pmem_resp & BUSY_D. Both are combinational, in the same cycle as pmem_resp.
  - i_rdata and d_rdata are wired to pmem_rdata.
  - On pmem_resp: clear pmem_read/pmem_write at the edge and go to RECOVER.
- RECOVER: one cycle with no grant, which gives the requester time to drop its request. Then go to IDLE.
- A requester dropping its request mid-BUSY does not abort the transaction. It completes and the resp pulse is still issued.
- Timeout:
  - The counter is cleared on entry to BUSY_x and increments each BUSY cycle without pmem_resp.
  - At count==TIMEOUT, err_timeout is set and the counter saturates.
  - The transaction keeps waiting. err_timeout clears only on reset.
- pmem_resp in IDLE or RECOVER is ignored: no resp pulse and no state change.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, last_grant=D so I wins the first tie.
  - pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp, err_timeout and the counter all read 0.
- Request seen at edge E in IDLE: pmem command is visible from E+1.
- pmem_resp in cycle N:
  - Cache resp in cycle N.
  - pmem command low from N+1 (RECOVER).
  - IDLE at N+2; the next grant is sampled at the end of N+2, with the command at N+3.
- Minimum turnaround between back-to-back transactions: 2 idle pmem cycles.
- rst_n asserted mid-BUSY: outputs drop immediately and the in-flight transaction is abandoned. A later stray pmem_resp is ignored.

## Test plan
- Single I read, addr 0x0000_0040, pmem_resp after 5 cycles:
  - pmem_read=1, pmem_address=0x40 from the cycle after the request.
  - i_resp pulses 1 cycle with i_rdata=pmem_rdata; d_resp stays 0.
- D writeback, d_addr 0x8000_0020, d_wdata=all 0xA5:
  - pmem_write=1 with pmem_wdata=0xA5…A5, pmem_read=0.
  - d_resp on pmem_resp.
- i_read and d_read held high together after reset:
  - Grants alternate I, D, I, D.
  - Each transaction has exactly one resp pulse and 2 idle cycles between commands.
- d_read and d_write both high: pmem_write=1, pmem_read=0.
- TIMEOUT=4, pmem_resp withheld:
  - err_timeout rises on the 4th busy cycle without resp and stays 1 after a later pmem_resp completes the transaction.
  - Only reset clears it.
- rst_n pulsed low mid-BUSY_D:
  - All outputs go 0 immediately.
  - A subsequent pmem_resp produces no d_resp.
  - The next tie grants I first.
